// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

   localparam int SA_WIDTH_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/serial_adder_fulladdcomb.sv
// Combinational one-bit full-adder cell driven by the serial adder each bit-cycle.
module fulladdcomb (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sumf,
   output logic carryf
);

   assign sumf   = a ^ b ^ cin;
   assign carryf = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in; one operand bit pair per cycle through fulladdcomb.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_sh_reg;
   logic [WIDTH-1:0]   b_sh_reg;
   logic [WIDTH-1:0]   sum_reg;
   logic               carry_reg;
   logic               cout_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               accept;
   logic               last_bit;
   logic               cell_sum;
   logic               cell_carry;

   fulladdcomb u_cell (
      .a      (a_sh_reg[0]),
      .b      (b_sh_reg[0]),
      .cin    (carry_reg),
      .sumf   (cell_sum),
      .carryf (cell_carry)
   );

   assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (last_bit) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = S_RUN;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
         end else if (state_reg == S_RUN) begin
            a_sh_reg  <= a_sh_reg >> 1;
            b_sh_reg  <= b_sh_reg >> 1;
            // New sum bit enters at the MSB; after WIDTH shifts every bit sits in place.
            sum_reg   <= {cell_sum, sum_reg[WIDTH-1:1]};
            carry_reg <= cell_carry;
            cout_reg  <= cell_carry;
            cnt_reg   <= last_bit ? '0 : cnt_reg + CNT_W'(1);
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_reg;

   // On the MSB cycle the stored carry is the carry into bit WIDTH-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (accept) begin
         ovf_reg <= 1'b0;
      end else if (state_reg == S_RUN && last_bit) begin
         ovf_reg <= carry_reg ^ cell_carry;
      end
   end

   assign ovf = ovf_reg;
`endif

   assign busy = (state_reg == S_RUN);
   assign done = (state_reg == S_DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8); define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start with operands and record the expected result.
   task automatic push_exp(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      logic [W:0] full;
      exp_t       e;
      full   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
      sb.push_back(e);
   endtask

   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      start = 1'b1;
      a     = xa;
      b     = xb;
      cin   = xc;
      push_exp(xa, xb, xc);
      step();
      start = 1'b0;
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_sum"}, 32'(sum), 32'(e.sum));
         check({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
         check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
   endtask

   // n0 = cycle index after the accepting edge at which collection begins.
   task automatic collect(input string tag, input int n0);
      int n;
      int busy_cnt;
      n        = n0;
      busy_cnt = 0;
      while (done !== 1'b1 && n < 20) begin
         if (busy === 1'b1) busy_cnt++;
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd9);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(9 - n0));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      check_result(tag);
   endtask

   initial begin
      logic [W-1:0] btab [8];
      int           done_seen;
      btab = '{8'h00, 8'h01, 8'h55, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h00};

      // Reset state
      repeat (3) step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      step();

      launch(8'h05, 8'h03, 1'b0);
      collect("add_05_03", 1);
      step();
      check("idle_after_done", 32'(done), 32'd0);

      launch(8'hFF, 8'h01, 1'b0);
      collect("add_ff_01", 1);
      launch(8'hFF, 8'hFF, 1'b1);
      collect("add_ff_ff_c", 1);
      launch(8'h7F, 8'h01, 1'b0);
      collect("add_7f_01", 1);

      // start pulsed in RUN cycle 3 must be ignored
      launch(8'h12, 8'h34, 1'b0);
      step();
      step();
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'hAA;
      step();
      start = 1'b0;
      collect("ignore_run_start", 4);
      step();
      check("no_queued_busy", 32'(busy), 32'd0);
      check("no_queued_done", 32'(done), 32'd0);

      // Back-to-back: start held from the last RUN cycle through DONE
      launch(8'h21, 8'h43, 1'b1);
      repeat (7) step();
      start = 1'b1;
      a     = 8'h9C;
      b     = 8'h77;
      cin   = 1'b0;
      step();
      check("b2b_first_done", 32'(done), 32'd1);
      check_result("b2b_first");
      push_exp(8'h9C, 8'h77, 1'b0);
      step();
      start = 1'b0;
      check("b2b_no_idle", 32'(busy), 32'd1);
      collect("b2b_second", 1);

      // Reset in RUN cycle 4 discards the operation
      launch(8'h55, 8'h66, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("midrst_ovf", 32'(ovf), 32'd0);
`endif
      void'(sb.pop_back());
      step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      check("postrst_quiet", 32'(done_seen), 32'd0);
      launch(8'h10, 8'h20, 1'b0);
      collect("postrst_10_20", 1);

      // Operand sweep: every a, a spread of b values, both carry-ins
      for (int ia = 0; ia < 256; ia++) begin
         for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < 2; c++) begin
               logic [W-1:0] vb;
               vb = (j == 7) ? W'($urandom_range(0, 255)) : btab[j];
               launch(W'(ia), vb, c[0]);
               collect($sformatf("sweep_%02h_%02h_%0d", ia, vb, c), 1);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
